// File: rtl/el2_gpr_sched_pkg.sv
// Shared types and helpers for the GPR write-port scheduler.
// Register x0 is hardwired, so the one-hot decode starts at x1.
package el2_gpr_sched_pkg;

  localparam int GPR_NUM_WR_PORTS = 3;
  localparam int GPR_DW           = 32;

  typedef struct packed {
    logic [4:0]        addr;
    logic [GPR_DW-1:0] data;
  } gpr_wr_req_t;

  function automatic logic [31:1] gpr_dec5(input logic [4:0] idx);
    logic [31:1] oh;
    oh = 31'd0;
    if (idx != 5'd0) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/el2_rr_pick2.sv
// Two-winner round-robin picker. The second pick ignores every requester
// that shares the first winner's destination register.
module el2_rr_pick2 #(
  parameter int N = 3
) (
  input  logic [N-1:0]   req,
  input  logic [2:0]     ptr,
  input  logic [N*N-1:0] same_addr,
  output logic [N-1:0]   gnt1,
  output logic [N-1:0]   gnt2
);

  function automatic logic [N-1:0] rr_first(input logic [N-1:0] r, input logic [2:0] p);
    logic [N-1:0] g;
    logic         hit;
    int           pos;
    g   = {N{1'b0}};
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(p) + k;
      if (pos >= N) pos = pos - N;
      for (int i = 0; i < N; i++) begin
        if (!hit && r[i] && (pos == i)) begin
          g[i] = 1'b1;
          hit  = 1'b1;
        end
      end
    end
    return g;
  endfunction

  logic [N-1:0] excl;
  logic [N-1:0] req2;

  // First winner, then a second winner from the address-filtered remainder.
  always_comb begin
    excl = {N{1'b0}};
    gnt1 = rr_first(req, ptr);
    for (int i = 0; i < N; i++) begin
      if (gnt1[i]) excl = excl | same_addr[i*N +: N];
      else         excl = excl;
    end
    req2 = req & ~gnt1 & ~excl;
    gnt2 = rr_first(req2, ptr);
  end

endmodule

// File: rtl/el2_rvdffe_ar.sv
// Enable flop with asynchronous active-high reset (rvdffe variant).
module el2_rvdffe_ar #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q;

  // Capture din only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout_q <= {WIDTH{1'b0}};
    else if (en) dout_q <= din;
  end

  assign dout = dout_q;

endmodule

// File: rtl/el2_dec_gpr_wr_sched.sv
// GPR write-port scheduler: source 0 owns port 0; one-entry slots for the
// other sources drain round-robin onto ports 1 and 2.
module el2_dec_gpr_wr_sched
  import el2_gpr_sched_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src_valid,
  output logic [NSRC-1:0]   src_ready,
  input  logic [NSRC*5-1:0] src_addr,
  input  logic [NSRC*DW-1:0] src_data,
  output logic              wen0,
  output logic [4:0]        waddr0,
  output logic [DW-1:0]     wd0,
  output logic              wen1,
  output logic [4:0]        waddr1,
  output logic [DW-1:0]     wd1,
  output logic              wen2,
  output logic [4:0]        waddr2,
  output logic [DW-1:0]     wd2,
  output logic [31:1]       busy,
  output logic [NSRC-1:0]   drop
);

  localparam int NS = NSRC - 1;
  localparam int SW = 1 + 5 + DW;

  logic [NS-1:0]          slot_v, fire, leave, drop_s, elig, gnt1, gnt2, last_g;
  logic [NS-1:0][4:0]     slot_addr;
  logic [NS-1:0][DW-1:0]  slot_data;
  logic [NS*NS-1:0]       same_addr;
  logic [2:0]             ptr_q, ptr_d;
  logic [4:0]             addr0;
  logic                   wen0_s;

  assign addr0  = src_addr[4:0];
  assign wen0_s = ~rst & src_valid[0] & (addr0 != 5'd0);
  assign wen0   = wen0_s;
  assign waddr0 = rst ? 5'd0 : addr0;
  assign wd0    = rst ? {DW{1'b0}} : src_data[DW-1:0];

  for (genvar s = 0; s < NS; s++) begin : g_slot
    logic [4:0]    a_in;
    logic [SW-1:0] din, dout;
    assign a_in    = src_addr[(s+1)*5 +: 5];
    assign fire[s] = src_valid[s+1] & src_ready[s+1];
    // x0 requests are accepted but leave the slot empty.
    assign din     = {fire[s] & (a_in != 5'd0), a_in, src_data[(s+1)*DW +: DW]};

    el2_rvdffe_ar #(.WIDTH(SW)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .en   (fire[s] | leave[s]),
      .din  (din),
      .dout (dout)
    );

    assign slot_v[s]    = dout[SW-1];
    assign slot_addr[s] = dout[DW +: 5];
    assign slot_data[s] = dout[DW-1:0];
  end

  // A slot hit by a same-cycle pipeline write is superseded and never drains.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      drop_s[i] = slot_v[i] & wen0_s & (slot_addr[i] == addr0);
      elig[i]   = slot_v[i] & ~drop_s[i];
      for (int j = 0; j < NS; j++) begin
        same_addr[i*NS + j] = (slot_addr[i] == slot_addr[j]);
      end
    end
  end

  el2_rr_pick2 #(.N(NS)) u_pick (
    .req       (elig),
    .ptr       (ptr_q - 3'd1),
    .same_addr (same_addr),
    .gnt1      (gnt1),
    .gnt2      (gnt2)
  );

  assign leave     = gnt1 | gnt2 | drop_s;
  assign src_ready = {~slot_v | leave, 1'b1};
  assign drop      = {drop_s, 1'b0};

  // Drain ports are one-hot AND-OR muxes of the slot registers.
  always_comb begin
    busy   = 31'd0;
    wen1   = |gnt1;
    wen2   = |gnt2;
    waddr1 = 5'd0;
    waddr2 = 5'd0;
    wd1    = {DW{1'b0}};
    wd2    = {DW{1'b0}};
    for (int i = 0; i < NS; i++) begin
      if (slot_v[i]) busy = busy | gpr_dec5(slot_addr[i]);
      else           busy = busy;
      if (gnt1[i]) begin
        waddr1 = waddr1 | slot_addr[i];
        wd1    = wd1 | slot_data[i];
      end else begin
        waddr1 = waddr1;
      end
      if (gnt2[i]) begin
        waddr2 = waddr2 | slot_addr[i];
        wd2    = wd2 | slot_data[i];
      end else begin
        waddr2 = waddr2;
      end
    end
  end

  // Pointer moves past the last slot granted this cycle (slots numbered 1..NS).
  always_comb begin
    ptr_d  = ptr_q;
    last_g = (|gnt2) ? gnt2 : gnt1;
    for (int i = 0; i < NS; i++) begin
      if (last_g[i]) ptr_d = (i == NS - 1) ? 3'd1 : 3'(i + 2);
      else           ptr_d = ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 3'd1;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_el2_dec_gpr_wr_sched.sv
// Randomized bench for el2_dec_gpr_wr_sched against a slot-level reference
// model, plus directed scenarios with literal expectations.
module tb_el2_dec_gpr_wr_sched;

  localparam int NSRC = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC-1:0]   src_valid, src_ready, drop;
  logic [NSRC*5-1:0] src_addr;
  logic [NSRC*DW-1:0] src_data;
  logic              wen0, wen1, wen2;
  logic [4:0]        waddr0, waddr1, waddr2;
  logic [DW-1:0]     wd0, wd1, wd2;
  logic [31:1]       busy;

  el2_dec_gpr_wr_sched #(.NSRC(NSRC), .DW(DW)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
    .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
    .wen2(wen2), .waddr2(waddr2), .wd2(wd2),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side stimulus state
  bit [3:0]  sv;
  bit [4:0]  sa [4];
  bit [31:0] sd [4];

  // Reference model: slot contents and round-robin pointer
  bit        mv [1:3];
  bit [4:0]  ma [1:3];
  bit [31:0] md [1:3];
  int        mptr = 1;
  bit        nv [1:3];
  bit [4:0]  na [1:3];
  bit [31:0] nd [1:3];
  int        nptr = 1;
  bit [3:0]  e_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int s = 0; s < NSRC; s++) begin
      src_valid[s]         = sv[s];
      src_addr[s*5 +: 5]   = sa[s];
      src_data[s*DW +: DW] = sd[s];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [4:0] rand_addr();
    return 5'($urandom_range(0, 9));
  endfunction

  // Commit the model's next state on each clock edge.
  always @(posedge clk) begin
    for (int s = 1; s <= 3; s++) begin
      mv[s] = nv[s];
      ma[s] = na[s];
      md[s] = nd[s];
    end
    mptr = nptr;
  end

  // Compute expected outputs from the model and compare every cycle.
  always @(negedge clk) begin : cmp
    int        g1, g2, s, last;
    bit        lv, fr;
    bit [4:0]  a0;
    bit [31:0] d0;
    bit        dr [1:3];
    bit        e_wen0, e_wen1, e_wen2, col;
    bit [4:0]  e_a0, e_a1, e_a2;
    bit [31:0] e_d0, e_d1, e_d2;
    bit [31:1] e_busy;
    bit [3:0]  e_drop;

    a0 = src_addr[4:0];
    d0 = src_data[31:0];
    e_wen0 = 0; e_wen1 = 0; e_wen2 = 0;
    e_a0 = 0; e_a1 = 0; e_a2 = 0;
    e_d0 = 0; e_d1 = 0; e_d2 = 0;
    e_busy = 0; e_drop = 0; e_rdy = 4'hF;
    g1 = 0; g2 = 0;

    if (rst) begin
      for (int k = 1; k <= 3; k++) nv[k] = 0;
      nptr = 1;
    end else begin
      e_wen0 = src_valid[0] && (a0 != 0);
      e_a0 = a0;
      e_d0 = d0;
      for (int k = 1; k <= 3; k++) begin
        dr[k] = mv[k] && e_wen0 && (ma[k] == a0);
        e_drop[k] = dr[k];
        if (mv[k]) e_busy[ma[k]] = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        s = ((mptr - 1 + k) % 3) + 1;
        if (mv[s] && !dr[s]) begin
          if (g1 == 0) g1 = s;
          else if (g2 == 0 && ma[s] != ma[g1]) g2 = s;
        end
      end
      if (g1 != 0) begin e_wen1 = 1; e_a1 = ma[g1]; e_d1 = md[g1]; end
      if (g2 != 0) begin e_wen2 = 1; e_a2 = ma[g2]; e_d2 = md[g2]; end
      for (int k = 1; k <= 3; k++) begin
        lv = (g1 == k) || (g2 == k) || dr[k];
        e_rdy[k] = !mv[k] || lv;
        fr = src_valid[k] && e_rdy[k];
        if (fr) begin
          nv[k] = (src_addr[k*5 +: 5] != 0);
          na[k] = src_addr[k*5 +: 5];
          nd[k] = src_data[k*DW +: DW];
        end else if (lv) begin
          nv[k] = 0; na[k] = ma[k]; nd[k] = md[k];
        end else begin
          nv[k] = mv[k]; na[k] = ma[k]; nd[k] = md[k];
        end
      end
      last = (g2 != 0) ? g2 : g1;
      nptr = (last == 0) ? mptr : ((last == 3) ? 1 : last + 1);
    end

    col = (wen0 && wen1 && waddr0 == waddr1) || (wen0 && wen2 && waddr0 == waddr2) ||
          (wen1 && wen2 && waddr1 == waddr2);
    chk("port0", {wen0, waddr0, wd0}, {e_wen0, e_a0, e_d0});
    chk("port1", {wen1, waddr1, wd1}, {e_wen1, e_a1, e_d1});
    chk("port2", {wen2, waddr2, wd2}, {e_wen2, e_a2, e_d2});
    chk("busy", busy, e_busy);
    chk("ready", src_ready, e_rdy);
    chk("drop", drop, e_drop);
    chk("collision", col, 1'b0);
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < NSRC; s++) begin
      sv[s] = 1'($urandom_range(0, 1)); sa[s] = rand_addr(); sd[s] = $urandom;
    end
    apply();
    #1;
    chk("rst_wen", {wen0, wen1, wen2}, 3'b000);
    chk("rst_busy", busy, 31'd0);
    chk("rst_ready", src_ready, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        sv[s] = 1'($urandom_range(0, 1)); sa[s] = rand_addr(); sd[s] = $urandom;
      end
      apply();
      tick();
      chk("rst_outs", {wen0, wen1, wen2, waddr0, waddr1, waddr2, drop}, 22'd0);
    end

    // Release reset; source 0 passes straight through
    rst = 1'b0;
    sv = 4'b0001; sa[0] = 5'd5; sd[0] = 32'hA5A5_0000;
    apply(); #1;
    chk("p0_pass", {wen0, waddr0, wd0}, {1'b1, 5'd5, 32'hA5A5_0000});
    tick();

    // Slot latency: x7 on source 1
    sv = 4'b0010; sa[1] = 5'd7; sd[1] = 32'h1234;
    apply(); tick();
    sv = 4'b0000; apply(); #1;
    chk("lat_busy", busy[7], 1'b1);
    chk("lat_port1", {wen1, waddr1, wd1}, {1'b1, 5'd7, 32'h1234});
    tick();
    chk("lat_clear", {busy[7], wen1}, 2'b00);

    // Bring the pointer back to slot 1 via a lone slot-3 write
    sv = 4'b1000; sa[3] = 5'd20; sd[3] = 32'h20;
    apply(); tick();
    sv = 4'b0000; apply(); tick(); tick();

    // Three full slots drain over two cycles
    sv = 4'b1110; sa[1] = 5'd3; sa[2] = 5'd4; sa[3] = 5'd5;
    sd[1] = 32'h33; sd[2] = 32'h44; sd[3] = 32'h55;
    apply(); tick();
    sv = 4'b0000; apply(); #1;
    chk("full_p1", {wen1, waddr1, wd1}, {1'b1, 5'd3, 32'h33});
    chk("full_p2", {wen2, waddr2, wd2}, {1'b1, 5'd4, 32'h44});
    chk("full_rdy", src_ready, 4'b0111);
    tick();
    chk("full_p1b", {wen1, waddr1, wd1}, {1'b1, 5'd5, 32'h55});
    chk("full_p2b", wen2, 1'b0);
    tick();

    // Supersede: pipeline write to x9 kills slot 2
    sv = 4'b0100; sa[2] = 5'd9; sd[2] = 32'h99;
    apply(); tick();
    sv = 4'b0001; sa[0] = 5'd9; sd[0] = 32'h900;
    apply(); #1;
    chk("sup_drop", drop, 4'b0100);
    chk("sup_p0", {wen0, waddr0, wd0}, {1'b1, 5'd9, 32'h900});
    chk("sup_noslot", {wen1, wen2}, 2'b00);
    tick();
    sv = 4'b0000; apply(); #1;
    chk("sup_after", {busy[9], drop}, 5'd0);

    // Same address in slots 1 and 3 with the pointer at 3
    sv = 4'b0100; sa[2] = 5'd13; sd[2] = 32'h13;
    apply(); tick();
    sv = 4'b1010; sa[1] = 5'd12; sd[1] = 32'h111; sa[3] = 5'd12; sd[3] = 32'h333;
    apply(); tick();
    sv = 4'b0000; apply(); #1;
    chk("same_first", {wen1, waddr1, wd1, wen2}, {1'b1, 5'd12, 32'h333, 1'b0});
    tick();
    chk("same_second", {wen1, waddr1, wd1, wen2}, {1'b1, 5'd12, 32'h111, 1'b0});
    tick();

    // x0 request is swallowed
    sv = 4'b0100; sa[2] = 5'd0; sd[2] = 32'hDEAD;
    apply(); tick();
    sv = 4'b0000; apply(); #1;
    chk("x0_none", {wen1, wen2, busy}, 33'd0);

    // Asynchronous reset with two slots pending
    sv = 4'b0110; sa[1] = 5'd21; sa[2] = 5'd22; sd[1] = 32'h21; sd[2] = 32'h22;
    apply(); tick();
    sv = 4'b0000; apply(); #1;
    chk("ar_pending", {busy[21], busy[22]}, 2'b11);
    rst = 1'b1; #1;
    chk("ar_clear", {wen0, wen1, wen2, waddr1, waddr2, busy, drop}, 48'd0);
    chk("ar_data", {wd1, wd2}, 64'd0);
    tick();
    rst = 1'b0; apply(); tick();

    // Randomized traffic with requesters holding until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int s = 1; s < NSRC; s++) begin
        if (sv[s] && e_rdy[s]) sv[s] = 1'b0;
        if (!sv[s] && $urandom_range(0, 2) != 0) begin
          sv[s] = 1'b1; sa[s] = rand_addr(); sd[s] = $urandom;
        end
      end
      sv[0] = 1'($urandom_range(0, 1)); sa[0] = rand_addr(); sd[0] = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      apply();
      tick();
    end
    rst = 1'b0;
    sv = 4'b0000; apply();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/el2_dec_gpr_wr_sched.md
Name: el2_dec_gpr_wr_sched

Overview:
- Write-port scheduler in front of the 31x32 GPR file (3 write ports, each with wen/waddr/wd).
- Source 0 is the in-order pipeline writeback. It is never stalled and always owns write port 0.
- Sources 1..NSRC-1 are out-of-band producers (nonblocking load return, divider, etc.). Each has a one-entry holding slot; a round-robin arbiter drains the slots onto write ports 1 and 2.
- Also exports a per-register pending-write scoreboard for the decode stall logic.

Parameters:
- NSRC, 4, number of write sources including source 0 (legal 2..8)
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- src_valid  in  NSRC  write request per source
- src_ready  out  NSRC  request accepted this cycle; bit 0 tied to 1
- src_addr  in  NSRC x 5  destination register per source
- src_data  in  NSRC x DW  write data per source
- wen0/waddr0/wd0  out  1/5/DW  GPR port 0 (source 0 only)
- wen1/waddr1/wd1  out  1/5/DW  GPR port 1 (slot drain)
- wen2/waddr2/wd2  out  1/5/DW  GPR port 2 (slot drain)
- busy  out  31  bit r (1..31) set while any slot holds a write to xr
- drop  out  NSRC  1-cycle pulse: slot write discarded because it was superseded

Behaviour:
- Reset (async, rst=1):
  - All slots invalid; RR pointer = 1.
  - wen0/1/2 = 0, waddr* = 0, wd* = 0.
  - busy = 0, drop = 0, src_ready[NSRC-1:1] = 1.
- Source 0, combinational pass-through:
  - wen0 = src_valid[0] & (src_addr[0] != 0); waddr0 = src_addr[0]; wd0 = src_data[0].
  - Zero latency. No holding slot.
- Slot accept, sources s >= 1:
  - src_ready[s] = ~slot_v[s] | slot_leaving[s], where slot_leaving = granted or dropped this cycle.
  - Handshake fires on src_valid & src_ready. Slot captures addr/data at the next clk edge.
  - src_addr == 0: the request is accepted but never enters the slot (x0 writes are discarded with no drop pulse).
  - Requester holds valid/addr/data stable until ready.
- Drain:
  - Earliest port write is the cycle after acceptance (latency 1).
  - Up to 2 slots are granted per cycle, in round-robin order starting at the pointer. The first grant goes to port 1, the second to port 2.
  - Ports are combinational from slot registers: wen1 = grant valid, waddr1/wd1 = slot contents. Same for port 2.
- Pointer update:
  - Moves to the index after the last granted slot, wrapping NSRC-1 -> 1.
  - Unchanged when nothing is granted.
- Conflict rules, evaluated each cycle in this order:
  1. A slot whose addr equals src_addr[0] while wen0 = 1 is dropped. The younger pipeline write supersedes it. The slot is cleared, drop[s] pulses, and there is no port write.
  2. Two eligible slots with the same addr: only the one earlier in RR order is granted. The other stays pending.
  3. Otherwise up to 2 grants are issued.
  - Result: waddr0/1/2 never collide while their wens are asserted. This is checked by the collision assertion.
- busy:
  - Combinational OR of decoded slot addresses for all valid slots.
  - Includes slots granted in the current cycle, which clear at the next edge.
- Simultaneous events:
  - A slot can be granted and reloaded by a new handshake in the same cycle. The new entry is visible next cycle.
  - A dropped slot can also accept a new request in the same cycle.
- Reset mid-operation: all pending slot writes are lost with no drop pulse. Upstream owns replay.
- drop[0] is always 0.

Decomposition:
- Shared package el2_gpr_sched_pkg:
  - typedef gpr_wr_req_t {addr[4:0], data[DW-1:0]}
  - constant GPR_NUM_WR_PORTS = 3
  - function gpr_dec5 (5-bit index -> 31-bit one-hot, x0 excluded)
- One sub-module: el2_rr_pick2. Input: request vector plus pointer. Output: first and second one-hot grants in RR order, with the same-address exclusion mask applied before the second pick.
- Slots are NSRC-1 instances of the existing enable flop (rvdffe style) with an async active-high reset variant.

Test Plan:
- Reset then idle: rst=1 with random inputs -> all wen=0, busy=0, src_ready=4'b1111. After release, src_valid[0]=1, addr=5, data=0xA5A5_0000 -> same cycle wen0=1, waddr0=5, wd0=0xA5A5_0000.
- Slot latency: src1 writes x7 = 0x1234 at cycle N -> busy[7]=1 at N+1, wen1=1/waddr1=7/wd1=0x1234 at N+1, busy[7]=0 at N+2.
- Three slots full (x3, x4, x5 on src1..3), pointer=1 -> cycle 1: ports 1/2 = x3/x4. Cycle 2: port 1 = x5. Pointer ends at 1 after wrap; src_ready[1..2] reasserted in cycle 1.
- Supersede: slot2 holds x9 and src0 writes x9 in the same cycle -> drop[2]=1, only wen0 writes x9, busy[9]=0 next cycle.
- Same-address slots: src1 and src3 both hold x12, pointer=3 -> src3 granted first, src1 written the following cycle, never two wens with waddr=12.
- x0 and async reset: src2 writes x0 -> no wen and no busy bit. Reset asserted while 2 slots are valid -> all outputs 0 immediately, before the next clk edge.
